// File: rtl/testpattern_checker.sv
// Test-pattern reader: rebuilds h/v position from N64 syncs, locks on frame length and checks checkerboard pixels.
// Optional first-error position capture is enabled by defining TESTPATTERN_CHECKER_STICKY_ERR_EN.

module testpattern_checker #(
  parameter int         CW          = 8,
  parameter logic [9:0] HSTART_NTSC = 10'd64,
  parameter logic [9:0] HSTOP_NTSC  = 10'd704,
  parameter logic [8:0] VSTART_NTSC = 9'd16,
  parameter logic [8:0] VSTOP_NTSC  = 9'd256,
  parameter logic [9:0] HSTART_PAL  = 10'd64,
  parameter logic [9:0] HSTOP_PAL   = 10'd704,
  parameter logic [8:0] VSTART_PAL  = 9'd20,
  parameter logic [8:0] VSTOP_PAL   = 9'd308,
  parameter logic [8:0] PAL_THRESH  = 9'd288
) (
  input  logic            VCLK,
  input  logic            nRST,
  input  logic            nVDSYNC,
  input  logic [3*CW+3:0] vdata_in,
  input  logic            clr_err,
  output logic            locked,
  output logic            palmode_det,
  output logic [8:0]      lines_per_frame,
  output logic            frame_ok,
  output logic            frame_stb,
  output logic [15:0]     err_cnt,
  output logic [9:0]      err_hpos,
  output logic [8:0]      err_vpos
);

  localparam int DW = 3 * CW;

  typedef enum logic [1:0] {
    ST_SEARCH,
    ST_MEASURE,
    ST_CONFIRM,
    ST_CHECK
  } state_t;

  state_t        state_q, state_d;
  logic [3:0]    sync_q, sync_d;
  logic [9:0]    hcnt_q, hcnt_d;
  logic [8:0]    vcnt_q, vcnt_d;
  logic [8:0]    line_acc_q, line_acc_d;
  logic          prev_bit_q, prev_bit_d;
  logic          frame_err_q, frame_err_d;
  logic          locked_q, locked_d;
  logic          palmode_q, palmode_d;
  logic [8:0]    lpf_q, lpf_d;
  logic          frame_ok_q, frame_ok_d;
  logic          frame_stb_q, frame_stb_d;
  logic [15:0]   err_cnt_q, err_cnt_d;

  logic          valid;
  logic          vs_fall;
  logic          hs_fall;
  logic [DW-1:0] colour;
  logic [DW-1:0] expected;
  logic [9:0]    hstart, hstop;
  logic [8:0]    vstart, vstop;
  logic          in_win;
  logic          exp_bit;
  logic          pix_err;
  logic [8:0]    frame_lines;
  logic          sync_unused;

  assign valid       = ~nVDSYNC;
  assign colour      = vdata_in[DW-1:0];
  assign vs_fall     = valid & sync_q[3] & ~vdata_in[DW+3];
  assign hs_fall     = valid & sync_q[1] & ~vdata_in[DW+1];
  assign sync_unused = sync_q[2] ^ sync_q[0];

  // A line ending on the same sample as the frame still belongs to the finished frame.
  assign frame_lines = (line_acc_q == 9'h1FF) ? line_acc_q : line_acc_q + {8'd0, hs_fall};

  always_comb begin
    hstart = HSTART_NTSC;
    hstop  = HSTOP_NTSC;
    vstart = VSTART_NTSC;
    vstop  = VSTOP_NTSC;
    if (palmode_q) begin
      hstart = HSTART_PAL;
      hstop  = HSTOP_PAL;
      vstart = VSTART_PAL;
      vstop  = VSTOP_PAL;
    end
    in_win   = (vcnt_q >= vstart) && (vcnt_q < vstop) &&
               (hcnt_q >= hstart) && (hcnt_q < hstop);
    exp_bit  = (hcnt_q == hstart) ? vcnt_q[0] : ~prev_bit_q;
    expected = in_win ? {DW{exp_bit}} : '0;
    pix_err  = valid && (state_q == ST_CHECK) && (colour != expected);
  end

  always_comb begin
    sync_d      = sync_q;
    hcnt_d      = hcnt_q;
    vcnt_d      = vcnt_q;
    prev_bit_d  = prev_bit_q;
    frame_err_d = frame_err_q;
    err_cnt_d   = err_cnt_q;
    if (valid) begin
      sync_d     = vdata_in[DW+3:DW];
      prev_bit_d = colour[0];
      if (hs_fall) begin
        hcnt_d = 10'd0;
        vcnt_d = (vcnt_q == 9'h1FF) ? vcnt_q : vcnt_q + 9'd1;
      end else begin
        hcnt_d = (hcnt_q == 10'h3FF) ? hcnt_q : hcnt_q + 10'd1;
      end
      if (vs_fall) begin
        vcnt_d = 9'd0;
      end
      frame_err_d = vs_fall ? 1'b0 : (frame_err_q | pix_err);
      if (clr_err) begin
        err_cnt_d = 16'd0;
      end else if (pix_err && (err_cnt_q != 16'hFFFF)) begin
        err_cnt_d = err_cnt_q + 16'd1;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    line_acc_d  = line_acc_q;
    locked_d    = locked_q;
    palmode_d   = palmode_q;
    lpf_d       = lpf_q;
    frame_ok_d  = frame_ok_q;
    frame_stb_d = 1'b0;
    if (valid) begin
      line_acc_d = vs_fall ? 9'd0 : frame_lines;
      unique case (state_q)
        ST_SEARCH: begin
          line_acc_d = 9'd0;
          if (vs_fall) begin
            state_d = ST_MEASURE;
          end
        end
        ST_MEASURE: begin
          if (vs_fall) begin
            lpf_d     = frame_lines;
            palmode_d = (frame_lines > PAL_THRESH);
            state_d   = ST_CONFIRM;
          end
        end
        ST_CONFIRM: begin
          if (vs_fall) begin
            if (frame_lines == lpf_q) begin
              locked_d = 1'b1;
              state_d  = ST_CHECK;
            end else begin
              lpf_d     = frame_lines;
              palmode_d = (frame_lines > PAL_THRESH);
            end
          end
        end
        ST_CHECK: begin
          if (vs_fall) begin
            frame_stb_d = 1'b1;
            frame_ok_d  = ~(frame_err_q | pix_err);
            // A changed frame length drops lock and needs one confirming frame.
            if (frame_lines != lpf_q) begin
              locked_d   = 1'b0;
              frame_ok_d = 1'b0;
              lpf_d      = frame_lines;
              palmode_d  = (frame_lines > PAL_THRESH);
              state_d    = ST_CONFIRM;
            end
          end
        end
        default: state_d = ST_SEARCH;
      endcase
    end
  end

  always_ff @(posedge VCLK) begin
    if (!nRST) begin
      state_q     <= ST_SEARCH;
      sync_q      <= 4'hF;
      hcnt_q      <= 10'd0;
      vcnt_q      <= 9'd0;
      line_acc_q  <= 9'd0;
      prev_bit_q  <= 1'b0;
      frame_err_q <= 1'b0;
      locked_q    <= 1'b0;
      palmode_q   <= 1'b0;
      lpf_q       <= 9'd0;
      frame_ok_q  <= 1'b0;
      frame_stb_q <= 1'b0;
      err_cnt_q   <= 16'd0;
    end else begin
      state_q     <= state_d;
      sync_q      <= sync_d;
      hcnt_q      <= hcnt_d;
      vcnt_q      <= vcnt_d;
      line_acc_q  <= line_acc_d;
      prev_bit_q  <= prev_bit_d;
      frame_err_q <= frame_err_d;
      locked_q    <= locked_d;
      palmode_q   <= palmode_d;
      lpf_q       <= lpf_d;
      frame_ok_q  <= frame_ok_d;
      frame_stb_q <= frame_stb_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

`ifdef TESTPATTERN_CHECKER_STICKY_ERR_EN
  logic       err_capt_q, err_capt_d;
  logic [9:0] err_hpos_q, err_hpos_d;
  logic [8:0] err_vpos_q, err_vpos_d;

  // Only the first error after a clear is recorded; later ones leave the position alone.
  always_comb begin
    err_capt_d = err_capt_q;
    err_hpos_d = err_hpos_q;
    err_vpos_d = err_vpos_q;
    if (valid) begin
      if (clr_err) begin
        err_capt_d = 1'b0;
        err_hpos_d = 10'd0;
        err_vpos_d = 9'd0;
      end else if (pix_err && !err_capt_q) begin
        err_capt_d = 1'b1;
        err_hpos_d = hcnt_q;
        err_vpos_d = vcnt_q;
      end
    end
  end

  always_ff @(posedge VCLK) begin
    if (!nRST) begin
      err_capt_q <= 1'b0;
      err_hpos_q <= 10'd0;
      err_vpos_q <= 9'd0;
    end else begin
      err_capt_q <= err_capt_d;
      err_hpos_q <= err_hpos_d;
      err_vpos_q <= err_vpos_d;
    end
  end

  assign err_hpos = err_hpos_q;
  assign err_vpos = err_vpos_q;
`else
  assign err_hpos = 10'd0;
  assign err_vpos = 9'd0;
`endif

  assign locked          = locked_q;
  assign palmode_det     = palmode_q;
  assign lines_per_frame = lpf_q;
  assign frame_ok        = frame_ok_q;
  assign frame_stb       = frame_stb_q;
  assign err_cnt         = err_cnt_q;

endmodule

// File: tb/tb_testpattern_checker.sv
// Directed bench for testpattern_checker: a short-line checkerboard generator drives NTSC/PAL frames.
// Horizontal window is shrunk to [2,4) so that a 6-sample line keeps full frames short.

module tb_testpattern_checker;

  localparam int CW       = 8;
  localparam int LINE_LEN = 6;

  logic            VCLK;
  logic            nRST;
  logic            nVDSYNC;
  logic [3*CW+3:0] vdata_in;
  logic            clr_err;
  logic            locked;
  logic            palmode_det;
  logic [8:0]      lines_per_frame;
  logic            frame_ok;
  logic            frame_stb;
  logic [15:0]     err_cnt;
  logic [9:0]      err_hpos;
  logic [8:0]      err_vpos;

  int checks = 0;
  int errors = 0;

  int gen_line;
  int gen_k;
  int gen_lines;
  bit gen_pal;

  logic [9:0] exp_hpos;
  logic [8:0] exp_vpos;

  testpattern_checker #(
    .CW         (CW),
    .HSTART_NTSC(10'd2),
    .HSTOP_NTSC (10'd4),
    .HSTART_PAL (10'd2),
    .HSTOP_PAL  (10'd4)
  ) dut (
    .VCLK           (VCLK),
    .nRST           (nRST),
    .nVDSYNC        (nVDSYNC),
    .vdata_in       (vdata_in),
    .clr_err        (clr_err),
    .locked         (locked),
    .palmode_det    (palmode_det),
    .lines_per_frame(lines_per_frame),
    .frame_ok       (frame_ok),
    .frame_stb      (frame_stb),
    .err_cnt        (err_cnt),
    .err_hpos       (err_hpos),
    .err_vpos       (err_vpos)
  );

  initial VCLK = 1'b0;
  always #5 VCLK = ~VCLK;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // One valid sample of the pattern stream; vsync falls together with hsync at line 0, sample 0.
  task automatic applyStimulus(input logic [23:0] flip, input bit flood);
    int         h;
    int         vs;
    int         ve;
    logic       nv;
    logic       nh;
    logic       pix;
    logic       in_win;
    logic [23:0] colour;
    nv     = (gen_line >= 3);
    nh     = (gen_k != 0);
    h      = (gen_k == 0) ? LINE_LEN - 1 : gen_k - 1;
    vs     = gen_pal ? 20 : 16;
    ve     = gen_pal ? 308 : 256;
    in_win = (gen_line >= vs) && (gen_line < ve) && (h >= 2) && (h < 4);
    pix    = (((gen_line ^ h) & 1) != 0);
    colour = in_win ? {24{pix}} : 24'h0;
    if (flood) colour = 24'h000001;
    colour   = colour ^ flip;
    nVDSYNC  = 1'b0;
    vdata_in = {nv, 1'b1, nh, nv & nh, colour};
    @(posedge VCLK);
    #1;
    gen_k++;
    if (gen_k == LINE_LEN) begin
      gen_k = 0;
      gen_line++;
      if (gen_line >= gen_lines) gen_line = 0;
    end
  endtask

  task automatic runTo(input int line, input int k);
    while (!(gen_line == line && gen_k == k)) applyStimulus(24'h0, 1'b0);
  endtask

  task automatic toVsync(input bit flood);
    while (!(gen_line == 0 && gen_k == 0)) applyStimulus(24'h0, flood);
    applyStimulus(24'h0, flood);
  endtask

  initial begin
    nRST      = 1'b0;
    nVDSYNC   = 1'b0;
    clr_err   = 1'b0;
    vdata_in  = {4'hF, 24'h0};
    gen_line  = 0;
    gen_k     = 0;
    gen_lines = 263;
    gen_pal   = 1'b0;
`ifdef TESTPATTERN_CHECKER_STICKY_ERR_EN
    exp_hpos = 10'd3;
    exp_vpos = 9'd100;
`else
    exp_hpos = 10'd0;
    exp_vpos = 9'd0;
`endif

    repeat (3) @(posedge VCLK);
    #1;
    checkOutput("reset_locked", locked, 0);
    checkOutput("reset_pal", palmode_det, 0);
    checkOutput("reset_lpf", lines_per_frame, 0);
    checkOutput("reset_err_cnt", err_cnt, 0);
    checkOutput("reset_frame_stb", frame_stb, 0);
    nRST = 1'b1;

    // NTSC: SEARCH -> MEASURE -> CONFIRM -> CHECK over three vsync edges.
    toVsync(1'b0);
    checkOutput("ntsc_vs1_locked", locked, 0);
    toVsync(1'b0);
    checkOutput("ntsc_vs2_lpf", lines_per_frame, 263);
    checkOutput("ntsc_vs2_locked", locked, 0);
    toVsync(1'b0);
    checkOutput("ntsc_vs3_locked", locked, 1);
    checkOutput("ntsc_vs3_pal", palmode_det, 0);
    toVsync(1'b0);
    checkOutput("ntsc_stb", frame_stb, 1);
    checkOutput("ntsc_frame_ok", frame_ok, 1);
    checkOutput("ntsc_err_cnt", err_cnt, 0);
    applyStimulus(24'h0, 1'b0);
    checkOutput("ntsc_stb_pulse_end", frame_stb, 0);

    // Single flipped colour bit at vcnt=100, hcnt=3 (sample 4 of the line).
    runTo(100, 4);
    applyStimulus(24'h000080, 1'b0);
    checkOutput("inj_err_cnt", err_cnt, 1);
    checkOutput("inj_err_hpos", err_hpos, exp_hpos);
    checkOutput("inj_err_vpos", err_vpos, exp_vpos);
    toVsync(1'b0);
    checkOutput("inj_stb", frame_stb, 1);
    checkOutput("inj_frame_ok", frame_ok, 0);
    checkOutput("inj_locked", locked, 1);

    // Non-valid slots carrying garbage and clr_err must change nothing.
    nVDSYNC  = 1'b1;
    clr_err  = 1'b1;
    vdata_in = {4'h0, 24'h000001};
    repeat (3) @(posedge VCLK);
    #1;
    clr_err = 1'b0;
    checkOutput("invalid_hold_err_cnt", err_cnt, 1);
    checkOutput("invalid_hold_locked", locked, 1);
    clr_err = 1'b1;
    applyStimulus(24'h0, 1'b0);
    clr_err = 1'b0;
    checkOutput("clr_err_cnt", err_cnt, 0);
    checkOutput("clr_err_hpos", err_hpos, 0);

    // Frame length changes from 263 to 264.
    gen_lines = 264;
    toVsync(1'b0);
    checkOutput("len_change_locked", locked, 0);
    checkOutput("len_change_lpf", lines_per_frame, 264);
    checkOutput("len_change_frame_ok", frame_ok, 0);
    toVsync(1'b0);
    checkOutput("len_relock_locked", locked, 1);

    // One-sample reset mid-frame, then the source switches to PAL.
    runTo(50, 2);
    nRST = 1'b0;
    applyStimulus(24'h0, 1'b0);
    checkOutput("midreset_locked", locked, 0);
    checkOutput("midreset_lpf", lines_per_frame, 0);
    checkOutput("midreset_err_cnt", err_cnt, 0);
    checkOutput("midreset_frame_ok", frame_ok, 0);
    nRST      = 1'b1;
    gen_lines = 313;
    gen_pal   = 1'b1;
    toVsync(1'b0);
    checkOutput("pal_vs1_locked", locked, 0);
    toVsync(1'b0);
    checkOutput("pal_vs2_lpf", lines_per_frame, 313);
    checkOutput("pal_vs2_pal", palmode_det, 1);
    checkOutput("pal_vs2_locked", locked, 0);
    toVsync(1'b0);
    checkOutput("pal_vs3_locked", locked, 1);
    toVsync(1'b0);
    checkOutput("pal_stb", frame_stb, 1);
    checkOutput("pal_frame_ok", frame_ok, 1);
    checkOutput("pal_err_cnt", err_cnt, 0);

    // Every sample wrong until the counter sits one below saturation.
    for (int i = 0; i < 65534; i++) applyStimulus(24'h0, 1'b1);
    checkOutput("flood_err_cnt", err_cnt, 16'hFFFE);
    checkOutput("flood_locked", locked, 1);
    checkOutput("flood_frame_ok", frame_ok, 0);
    applyStimulus(24'h0, 1'b1);
    checkOutput("sat_first", err_cnt, 16'hFFFF);
    applyStimulus(24'h0, 1'b1);
    checkOutput("sat_hold", err_cnt, 16'hFFFF);
    clr_err = 1'b1;
    applyStimulus(24'h0, 1'b1);
    clr_err = 1'b0;
    checkOutput("sat_clr_priority", err_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/testpattern_checker.md
Name: testpattern_checker

Overview:
- Reader side of the test-pattern video path: consumes the demuxed N64 video stream (sync + colour), rebuilds h/v position from the incoming syncs and checks every active pixel against the checkerboard rule the pattern generator writes.
- Sits after the PPU output register, ahead of the scaler/DAC stage. Reports lock, measured line count, PAL/NTSC detection and a pixel-error count for in-system self-test and debug readout.

Parameters:
- CW, 8, colour bits per channel; vdata_in width = 3*CW+4.
- HSTART_NTSC / HSTOP_NTSC, 10'd64 / 10'd704, horizontal check window, NTSC.
- VSTART_NTSC / VSTOP_NTSC, 9'd16 / 9'd256, vertical check window, NTSC.
- HSTART_PAL / HSTOP_PAL, 10'd64 / 10'd704, horizontal check window, PAL.
- VSTART_PAL / VSTOP_PAL, 9'd20 / 9'd308, vertical check window, PAL.
- PAL_THRESH, 9'd288, lines-per-frame above this means PAL.

Ports:
- VCLK  in  1  video clock; only clock.
- nRST  in  1  reset, synchronous, active-low.
- nVDSYNC  in  1  low = data-valid slot; all processing happens only in these cycles.
- vdata_in  in  3*CW+4  {nVSYNC, nCLAMP, nHSYNC, nCSYNC, R, G, B}, MSB first.
- clr_err  in  1  synchronous clear of err_cnt and the sticky capture.
- locked  out  1  two consecutive frames with equal line count seen.
- palmode_det  out  1  1 = PAL timing detected.
- lines_per_frame  out  9  line count of the last completed frame.
- frame_ok  out  1  last checked frame had zero pixel errors.
- frame_stb  out  1  one-VCLK pulse at each nVSYNC falling edge while in CHECK.
- err_cnt  out  16  saturating pixel-error count.
- err_hpos  out  10  hcnt of the first error (optional feature).
- err_vpos  out  9  vcnt of the first error (optional feature).

Behaviour:
- Reset (nRST low at a VCLK edge): all outputs 0; state SEARCH; hcnt = 0; vcnt = 0; sync_q = 4'hF.
- Valid cycle: nVDSYNC = 0. On other cycles every register holds its value.
- Edge detect per valid cycle:
  - vs_fall = sync_q[3] & ~vdata_in[3*CW+3]; hs_fall = sync_q[1] & ~vdata_in[3*CW+1].
  - sync_q <= the incoming sync nibble.
- Counters:
  - hs_fall: hcnt <= 0; vcnt <= vcnt+1, saturating at 9'h1FF.
  - Otherwise: hcnt <= hcnt+1, saturating at 10'h3FF.
  - vs_fall: vcnt <= 0, overriding hs_fall in the same cycle.
- Window select:
  - Window = PAL set when palmode_det = 1, else NTSC set.
  - In window when vcnt in [VSTART, VSTOP) and hcnt in [HSTART, HSTOP).
  - Comparisons use pre-update counter values.
- Expected colour (all 3*CW bits identical):
  - hcnt == HSTART: {vcnt[0]}.
  - HSTART < hcnt < HSTOP: ~prev_bit, where prev_bit = bit 0 of the previous valid sample.
  - Outside window: 0.
- Pixel error: the sample's colour differs from the expected value. Error logic is active only in state CHECK.
- FSM:
  - SEARCH: on vs_fall go to MEASURE; line_acc <= 0.
  - MEASURE: count hs_fall into line_acc. On vs_fall: lines_per_frame <= line_acc; palmode_det <= (line_acc > PAL_THRESH); go to CONFIRM.
  - CONFIRM: count one more frame. On vs_fall:
    - equal to lines_per_frame: locked <= 1, go to CHECK.
    - not equal: store the new count, stay in CONFIRM.
  - CHECK: on vs_fall, pulse frame_stb; frame_ok <= (no error in the finished frame); compare the new line count.
    - Mismatch: locked <= 0, frame_ok <= 0, go to CONFIRM with the new count stored.
- err_cnt:
  - +1 per erroneous valid sample, saturating at 16'hFFFF.
  - clr_err takes priority over an increment in the same cycle.
- Simultaneous hs_fall and vs_fall: the line is counted into line_acc before the frame compare.
- Missing syncs: hcnt/vcnt stick at saturation and samples outside the window are expected 0. The FSM stays in its state; no timeout.

Optional Feature:
- Macro: TESTPATTERN_CHECKER_STICKY_ERR_EN.
- Defined: on the first error after reset or clr_err, latch err_hpos/err_vpos from the current hcnt/vcnt and hold until clr_err or reset.
- Undefined: err_hpos and err_vpos are tied to 0 and no capture registers exist.

Test Plan:
- NTSC stream from the pattern generator: 263 lines/frame, 3 frames → locked=1 after the 2nd vs_fall following SEARCH, palmode_det=0, lines_per_frame=263, frame_ok=1, err_cnt=0.
- PAL stream, 313 lines → palmode_det=1, lines_per_frame=313, locked=1, err_cnt=0.
- Flip one colour bit at vcnt=100, hcnt=200 in a locked frame → err_cnt=1; frame_ok=0 at the next frame_stb; with the macro, err_hpos=200 and err_vpos=100.
- Switch line count from 263 to 264 mid-stream → locked=0 at that vs_fall; locked=1 again after one more 264-line frame.
- Pull nRST low for one valid cycle mid-frame → all outputs 0 at the next edge; FSM back in SEARCH; relock within 2 frames.
- Hold err_cnt at 16'hFFFE, inject 3 errors with clr_err pulsed in the cycle of the 3rd → err_cnt reads 16'hFFFF, then 0.
